// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 peripheral blocks.
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [1:0] {
    TMR_DIV,
    TMR_TIMA,
    TMR_TMA,
    TMR_TAC
  } tmr_reg_sel_t;

  typedef struct packed {
    logic [4:0] pad;
    logic       en;
    logic [1:0] clk_sel;
  } tac_t;

  typedef enum logic [1:0] {
    TMR_RUN,
    TMR_OVF,
    TMR_RELOAD
  } tmr_state_t;

  localparam int unsigned TIMA_BIT_SEL0 = 9;
  localparam int unsigned TIMA_BIT_SEL1 = 3;
  localparam int unsigned TIMA_BIT_SEL2 = 5;
  localparam int unsigned TIMA_BIT_SEL3 = 7;

  // Stored pad bits are always zero, so OR-ing reproduces the open-bus ones.
  function automatic data_t tac_read(input tac_t t);
    return data_t'(t) | 8'hF8;
  endfunction

endpackage

// File: rtl/sm83_fall_det.sv
// Registered falling-edge detector: fall is high while sig is low after a high sample.
module sm83_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = sig;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign fall = prev_q & ~sig;

endmodule

// File: rtl/sm83_timer.sv
// DIV/TIMA/TMA/TAC timer responder with delayed TMA reload and APU frame tick.
module sm83_timer
  import sm83_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF04,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned OVF_DELAY = 4,
  parameter int unsigned APU_BIT   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic        irq_timer,
  output logic        apu_tick
);

  localparam int unsigned DLY_W = $clog2(OVF_DELAY + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  data_t            tima_q, tima_d;
  data_t            tma_q, tma_d;
  data_t            rdata_q, rdata_d;
  tac_t             tac_q, tac_d;
  tmr_state_t       state_q, state_d;
  logic [DLY_W-1:0] delay_q, delay_d;

  logic [15:0]  off;
  tmr_reg_sel_t sel;
  logic         div_wr, tima_wr, tma_wr, tac_wr;
  logic         inc_sig, inc_fall, apu_sig;

  always_comb begin
    off     = addr - BASE_ADDR;
    hit     = (off[15:2] == '0);
    sel     = tmr_reg_sel_t'(off[1:0]);
    div_wr  = wr & hit & (sel == TMR_DIV);
    tima_wr = wr & hit & (sel == TMR_TIMA);
    tma_wr  = wr & hit & (sel == TMR_TMA);
    tac_wr  = wr & hit & (sel == TMR_TAC);
    apu_sig = cnt_q[APU_BIT];
    case (tac_q.clk_sel)
      2'b00:   inc_sig = cnt_q[TIMA_BIT_SEL0];
      2'b01:   inc_sig = cnt_q[TIMA_BIT_SEL1];
      2'b10:   inc_sig = cnt_q[TIMA_BIT_SEL2];
      default: inc_sig = cnt_q[TIMA_BIT_SEL3];
    endcase
    inc_sig = inc_sig & tac_q.en;
  end

  sm83_fall_det u_inc_fall (
    .clk  (clk),
    .rst  (rst),
    .sig  (inc_sig),
    .fall (inc_fall)
  );

  sm83_fall_det u_apu_fall (
    .clk  (clk),
    .rst  (rst),
    .sig  (apu_sig),
    .fall (apu_tick)
  );

  always_comb begin
    cnt_d   = cnt_q;
    tima_d  = tima_q;
    tma_d   = tma_q;
    tac_d   = tac_q;
    rdata_d = rdata_q;
    state_d = state_q;
    delay_d = delay_q;

    if (div_wr)    cnt_d = '0;
    else if (tick) cnt_d = cnt_q + 1'b1;

    if (tma_wr) tma_d = wdata;
    if (tac_wr) begin
      tac_d         = '0;
      tac_d.en      = wdata[2];
      tac_d.clk_sel = wdata[1:0];
    end

    if (rd && hit) begin
      case (sel)
        TMR_DIV:  rdata_d = cnt_q[CNT_W-1 -: 8];
        TMR_TIMA: rdata_d = tima_q;
        TMR_TMA:  rdata_d = tma_q;
        default:  rdata_d = tac_read(tac_q);
      endcase
    end

    case (state_q)
      TMR_RUN: begin
        if (tima_wr) begin
          tima_d = wdata;
        end else if (inc_fall) begin
          if (tima_q == 8'hFF) begin
            tima_d  = '0;
            state_d = TMR_OVF;
            delay_d = DLY_W'(OVF_DELAY);
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      TMR_OVF: begin
        if (tima_wr) begin
          tima_d  = wdata;
          state_d = TMR_RUN;
        end else begin
          if (inc_fall) tima_d = tima_q + 8'd1;
          if (tick) begin
            if (delay_q == DLY_W'(1)) state_d = TMR_RELOAD;
            else                      delay_d = delay_q - 1'b1;
          end
        end
      end
      TMR_RELOAD: begin
        // A TMA write in this cycle feeds straight through to TIMA.
        tima_d  = tma_wr ? wdata : tma_q;
        state_d = TMR_RUN;
      end
      default: state_d = TMR_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tima_q  <= '0;
      tma_q   <= '0;
      tac_q   <= '0;
      rdata_q <= '0;
      state_q <= TMR_RUN;
      delay_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
      delay_q <= delay_d;
    end
  end

  assign rdata     = rdata_q;
  assign irq_timer = (state_q == TMR_RELOAD);

endmodule

// File: tb/tb_sm83_timer.sv
// Self-checking bench for sm83_timer: directed scenarios plus random traffic vs a behavioural model.
module tb_sm83_timer;

  localparam logic [15:0] BASE = 16'hFF04;

  logic        clk = 1'b0;
  logic        rst, tick, wr, rd;
  logic [15:0] addr;
  logic [7:0]  wdata, rdata;
  logic        hit, irq_timer, apu_tick;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_irq = 0;
  int unsigned n_apu = 0;

  sm83_timer #(
    .BASE_ADDR (16'hFF04),
    .CNT_W     (16),
    .OVF_DELAY (4),
    .APU_BIT   (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .addr      (addr),
    .wdata     (wdata),
    .wr        (wr),
    .rd        (rd),
    .rdata     (rdata),
    .hit       (hit),
    .irq_timer (irq_timer),
    .apu_tick  (apu_tick)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, remaining-overflow-ticks counter and reload flag.
  int unsigned m_cnt;
  logic [7:0]  m_tima, m_tma, m_rdata;
  logic [2:0]  m_tac;
  int          m_ovf_left;
  bit          m_reload, m_inc_prev, m_apu_prev;
  int unsigned sel_tab [4] = '{9, 3, 5, 7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cbit(input int unsigned c, input int unsigned b);
    return ((c >> b) & 1) != 0;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tima = '0; m_tma = '0; m_tac = '0; m_rdata = '0;
    m_ovf_left = 0; m_reload = 0; m_inc_prev = 0; m_apu_prev = 0;
  endtask

  task automatic model_step();
    logic [15:0] o;
    bit          inr, inc_now, apu_now, inc_edge, ovf_start;
    int unsigned n_cnt;
    logic [7:0]  n_tima, n_tma;
    logic [2:0]  n_tac;
    if (rst) begin
      model_reset();
      return;
    end
    o         = addr - BASE;
    inr       = (o < 16'd4);
    inc_now   = m_tac[2] && cbit(m_cnt, sel_tab[m_tac[1:0]]);
    apu_now   = cbit(m_cnt, 12);
    inc_edge  = m_inc_prev && !inc_now;
    ovf_start = 0;
    if (rd && inr) begin
      case (o[1:0])
        2'd0:    m_rdata = 8'(m_cnt >> 8);
        2'd1:    m_rdata = m_tima;
        2'd2:    m_rdata = m_tma;
        default: m_rdata = {5'b11111, m_tac};
      endcase
    end
    n_cnt  = (wr && inr && o == 16'd0) ? 0 : (tick ? (m_cnt + 1) % 65536 : m_cnt);
    n_tma  = (wr && inr && o == 16'd2) ? wdata : m_tma;
    n_tac  = (wr && inr && o == 16'd3) ? wdata[2:0] : m_tac;
    n_tima = m_tima;
    if (m_reload) begin
      n_tima   = n_tma;
      m_reload = 0;
    end else if (wr && inr && o == 16'd1) begin
      n_tima     = wdata;
      m_ovf_left = 0;
    end else begin
      if (inc_edge) begin
        if (m_ovf_left == 0 && m_tima == 8'hFF) begin
          n_tima    = 8'h00;
          ovf_start = 1;
        end else begin
          n_tima = 8'(m_tima + 8'd1);
        end
      end
      if (m_ovf_left > 0 && tick) begin
        if (m_ovf_left == 1) begin
          m_reload   = 1;
          m_ovf_left = 0;
        end else begin
          m_ovf_left--;
        end
      end
      if (ovf_start) m_ovf_left = 4;
    end
    m_cnt = n_cnt; m_tima = n_tima; m_tma = n_tma; m_tac = n_tac;
    m_inc_prev = inc_now; m_apu_prev = apu_now;
  endtask

  // One clock: drive inputs, compare visible outputs, advance the model, move to next negedge.
  task automatic cyc(input bit r, input bit t, input bit w, input bit rr,
                     input logic [15:0] a, input logic [7:0] d);
    logic [15:0] o;
    rst = r; tick = t; wr = w; rd = rr; addr = a; wdata = d;
    #1;
    o = a - BASE;
    chk("hit", hit, o < 16'd4);
    chk("irq_timer", irq_timer, m_reload);
    chk("apu_tick", apu_tick, m_apu_prev && !cbit(m_cnt, 12));
    chk("rdata", rdata, m_rdata);
    if (irq_timer === 1'b1) n_irq++;
    if (apu_tick === 1'b1) n_apu++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit t);
    cyc(0, t, 0, 0, 16'h0000, 8'h00);
  endtask

  task automatic wr_reg(input int unsigned off, input logic [7:0] d);
    cyc(0, 0, 1, 0, BASE + 16'(off), d);
  endtask

  task automatic rd_chk(input string tag, input int unsigned off, input logic [7:0] exp);
    cyc(0, 0, 0, 1, BASE + 16'(off), 8'h00);
    chk(tag, rdata, exp);
  endtask

  task automatic ovf_case(input string tag, input int at, input int unsigned woff,
                          input logic [7:0] wd, input logic [7:0] exp_tima, input int unsigned exp_irq);
    cyc(1, 0, 0, 0, 16'h0000, 8'h00);
    wr_reg(3, 8'h05);
    wr_reg(2, 8'h80);
    wr_reg(1, 8'hFE);
    n_irq = 0;
    for (int s = 1; s <= 42; s++) begin
      if (s == at) cyc(0, 1, 1, 0, BASE + 16'(woff), wd);
      else         cyc(0, 1, 0, 1, BASE + 16'd1, 8'h00);
    end
    chk({tag, "_tima"}, rdata, exp_tima);
    chk({tag, "_irqs"}, n_irq, exp_irq);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int unsigned kind;
    rst = 1; tick = 0; wr = 0; rd = 0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_irq", irq_timer, 1'b0);
    chk("reset_apu", apu_tick, 1'b0);

    // 256 ticks: DIV moves to 1, TIMA stays disabled.
    cyc(1, 0, 0, 0, 16'h0000, 8'h00);
    n_irq = 0;
    repeat (256) idle(1);
    rd_chk("div_256", 0, 8'h01);
    rd_chk("tima_off", 1, 8'h00);
    chk("irq_none", n_irq, 0);

    ovf_case("reload",     0,  0, 8'h00, 8'h80, 1);
    ovf_case("ovf_cancel", 36, 1, 8'h42, 8'h42, 0);
    ovf_case("tma_in_rl",  38, 2, 8'h33, 8'h33, 1);
    ovf_case("tima_in_rl", 38, 1, 8'h99, 8'h80, 1);

    // DIV write while the selected bit is high glitches TIMA up by one.
    cyc(1, 0, 0, 0, 16'h0000, 8'h00);
    wr_reg(3, 8'h07);
    repeat (128) idle(1);
    rd_chk("tima_pre", 1, 8'h00);
    wr_reg(0, 8'h5A);
    rd_chk("div_clr", 0, 8'h00);
    rd_chk("tima_glitch", 1, 8'h01);

    // APU tick from a DIV write while cnt[12] is set.
    cyc(1, 0, 0, 0, 16'h0000, 8'h00);
    n_apu = 0;
    repeat (4096) idle(1);
    chk("apu_before", n_apu, 0);
    wr_reg(0, 8'h00);
    repeat (3) idle(0);
    chk("apu_divwr", n_apu, 1);
    wr_reg(3, 8'h00);
    rd_chk("tac_f8", 3, 8'hF8);
    wr_reg(3, 8'hFD);
    rd_chk("tac_fd", 3, 8'hFD);

    for (int i = 0; i < 4000; i++) begin
      a    = ($urandom % 8 != 0) ? 16'hFF02 + 16'($urandom % 8) : 16'($urandom);
      d    = 8'($urandom);
      if (a == 16'hFF05 && ($urandom % 2) == 0) d = ($urandom % 2) ? 8'hFF : 8'hFE;
      kind = $urandom % 4;
      cyc(($urandom % 600) == 0, ($urandom % 4) != 0, kind == 0, kind == 1, a, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
